// File: rtl/ctr_decrypt_stream.sv
// CTR-mode decryptor for one message at a time: requests a keystream block per counter value
// from an external AES core, XORs it with each ciphertext block, and streams plaintext out.
module ctr_decrypt_stream #(
  parameter int MAX_BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [127:0] iv,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [127:0] ct_data,
  input  logic         ct_last,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [127:0] pt_data,
  output logic         pt_last,
  output logic         aes_req,
  output logic [255:0] aes_key,
  output logic [127:0] aes_in,
  input  logic         aes_done,
  input  logic [127:0] aes_out,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(MAX_BLOCKS) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_BLOCKS);

  typedef enum logic [2:0] {IDLE, KREQ, KWAIT, CTWAIT, OUT} state_t;

  state_t        state;
  logic [127:0]  ctr;
  logic [127:0]  ks;
  logic [CW-1:0] blk_cnt;
  logic [CW-1:0] blk_cnt_inc;
  logic          overflow;

  assign blk_cnt_inc = blk_cnt + CW'(1);
  // A block that fills the message budget without being marked last ends the message itself.
  assign overflow    = (blk_cnt_inc == LIMIT) && !ct_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ct_ready <= 1'b0;
      pt_valid <= 1'b0;
      pt_last  <= 1'b0;
      pt_data  <= '0;
      aes_req  <= 1'b0;
      aes_key  <= '0;
      aes_in   <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ctr      <= '0;
      ks       <= '0;
      blk_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aes_key <= key;
            ctr     <= iv;
            aes_in  <= iv;
            blk_cnt <= '0;
            err     <= 1'b0;
            aes_req <= 1'b1;
            busy    <= 1'b1;
            state   <= KREQ;
          end
        end
        KREQ: begin
          aes_req <= 1'b0;
          state   <= KWAIT;
        end
        KWAIT: begin
          if (aes_done) begin
            ks       <= aes_out;
            ctr      <= ctr + 128'd1;
            ct_ready <= 1'b1;
            state    <= CTWAIT;
          end
        end
        CTWAIT: begin
          if (ct_valid) begin
            pt_data  <= ct_data ^ ks;
            pt_last  <= ct_last | overflow;
            blk_cnt  <= blk_cnt_inc;
            ct_ready <= 1'b0;
            pt_valid <= 1'b1;
            state    <= OUT;
            if (overflow) begin
              err <= 1'b1;
            end
          end
        end
        OUT: begin
          if (pt_ready) begin
            pt_valid <= 1'b0;
            if (pt_last) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              aes_req <= 1'b1;
              aes_in  <= ctr;
              state   <= KREQ;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ctr_decrypt_stream.md
CTR_DECRYPT_STREAM -- requirements
Module: ctr_decrypt_stream

Interface
REQ-001 SHALL have parameter MAX_BLOCKS, default 8, giving the maximum number of 128-bit blocks per message.
REQ-002 SHALL have port clk, input, 1, the system clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle pulse that begins a message; it is sampled only in IDLE.
REQ-005 SHALL have port key, input, 256, the AES-256 key, captured at start.
REQ-006 SHALL have port iv, input, 128, the initial counter block, captured at start.
REQ-007 SHALL have ports ct_valid (input, 1), ct_ready (output, 1), ct_data (input, 128) and ct_last (input, 1), forming the ciphertext stream.
REQ-008 SHALL have ports pt_valid (output, 1), pt_ready (input, 1), pt_data (output, 128) and pt_last (output, 1), forming the plaintext stream.
REQ-009 SHALL have ports aes_req (output, 1), aes_key (output, 256), aes_in (output, 128), aes_done (input, 1) and aes_out (input, 128), forming the keystream core port; aes_done is a one-cycle pulse.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port err, output, 1, a sticky overflow flag.

Function
REQ-012 SHALL implement states IDLE, KREQ, KWAIT, CTWAIT and OUT.
REQ-013 IDLE: on start, SHALL latch key and iv into ctr, clear blk_cnt and err, and go to KREQ next cycle.
REQ-014 KREQ: SHALL assert aes_req for exactly one cycle with aes_in=ctr and aes_key=latched key, then go to KWAIT.
REQ-015 KWAIT: SHALL hold aes_req low; on aes_done SHALL register aes_out into ks, set ctr=ctr+1 (full 128-bit, wrapping from all-ones to zero), and go to CTWAIT.
REQ-016 CTWAIT: SHALL drive ct_ready=1; on ct_valid&&ct_ready SHALL register pt_data=ct_data^ks and pt_last=ct_last, increment blk_cnt, and go to OUT.
REQ-017 OUT: SHALL hold pt_valid=1 with pt_data and pt_last stable until pt_ready is high.
REQ-018 On the OUT handshake with pt_last=1, SHALL go to IDLE; otherwise it SHALL go to KREQ.
REQ-019 ct_ready SHALL be high only in CTWAIT, and pt_valid SHALL be high only in OUT, so at most one block is in flight.
REQ-020 Latency SHALL be as follows: the ciphertext handshake registers pt_valid=1 on the next edge, and the OUT handshake causes aes_req on the next edge.
REQ-021 If blk_cnt would reach MAX_BLOCKS on a handshake whose ct_last=0, the block SHALL output with pt_last forced to 1, set err=1, and return to IDLE after its OUT handshake.
REQ-022 err SHALL remain 1 until the next accepted start or reset.
REQ-023 start outside IDLE SHALL be ignored, and key/iv changes after start SHALL have no effect.
REQ-024 An aes_done outside KWAIT SHALL be ignored.
REQ-025 ct_valid outside CTWAIT SHALL NOT be consumed.
REQ-026 pt_ready outside OUT SHALL have no effect.
REQ-027 blk_cnt SHALL be $clog2(MAX_BLOCKS)+1 bits wide.
REQ-028 The data path SHALL have no arithmetic other than the ctr increment and the 128-bit XOR.

Reset
REQ-029 rst SHALL force state=IDLE.
REQ-030 rst SHALL force ct_ready=0, pt_valid=0, pt_last=0, aes_req=0, busy=0 and err=0.
REQ-031 rst SHALL clear pt_data, aes_in, aes_key, ks, ctr and blk_cnt to zero.
REQ-032 rst asserted mid-message (any state) SHALL abandon the message, with no further pt_valid for it.
REQ-033 After rst mid-message, a late aes_done SHALL be ignored.
REQ-034 rst SHALL take priority over start on the same edge.

Verification
REQ-035 Single block: key=000102..1f, iv=00112233445566778899aabbccddeeff, AES model returns 8ea2b7ca516745bfeafc49904b496089, ct_data=that value with ct_last=1 -> pt_data=0, pt_last=1, then IDLE.
REQ-036 Three-block stream with pt_ready held low 5 cycles on block 2 -> pt_data stable throughout the stall, three aes_req pulses with aes_in=iv, iv+1 and iv+2, and no ct_ready while in OUT.
REQ-037 Counter wrap: iv=ffff..ff, two blocks -> the second aes_in=0000..00.
REQ-038 Overflow: MAX_BLOCKS=8 and 9 blocks with ct_last never set -> 8th output has pt_last=1, err=1, 9th block not accepted (ct_ready low), then IDLE.
REQ-039 rst asserted in KWAIT, then aes_done pulsed -> no pt_valid, busy=0; a new start with a different iv decrypts correctly.
REQ-040 Spurious inputs: start pulsed during CTWAIT, and aes_done pulsed during OUT -> no state change, ctr unchanged.
